// File: rtl/serial_word_deserializer_pkg.sv
// serial_word_deserializer_pkg
// Shared types and helpers for the serial word deserializer.
//   state_t      : receive FSM states (PARITY only reachable when
//                  SERIAL_WORD_DESERIALIZER_PARITY_EN is defined)
//   count_width  : bit-counter width needed to count 0..w
package serial_word_deserializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int unsigned count_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_word_deserializer_if.sv
// serial_word_deserializer_if
// Bundles the serial input side and the parallel valid/ready output side.
//   in_valid, in_first, in_bit          : serial bit stream (LSB first)
//   out_valid, out_ready, out_data      : one-entry word handshake
//   out_parity_err, resync, drop        : status flags / pulses
// Modports: slave = deserializer view, master = producer/consumer view.
interface serial_word_deserializer_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_first;
  logic         in_bit;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_parity_err;
  logic         resync;
  logic         drop;

  modport slave (
    input  in_valid, in_first, in_bit, out_ready,
    output out_valid, out_data, out_parity_err, resync, drop
  );

  modport master (
    output in_valid, in_first, in_bit, out_ready,
    input  out_valid, out_data, out_parity_err, resync, drop
  );
endinterface

// File: rtl/serial_out_reg.sv
// serial_out_reg
// One-entry valid/ready holding register.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : a new entry is offered this cycle
//   data_in   : entry to store
//   valid     : register holds an entry
//   ready     : consumer takes the entry when valid && ready
//   data_out  : held entry, stable while valid && !ready
//   drop      : registered pulse, load arrived while full and not draining
module serial_out_reg #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] data_in,
  output logic          valid,
  input  logic          ready,
  output logic [DW-1:0] data_out,
  output logic          drop
);

  logic can_load;

  assign can_load = !valid || ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= 1'b0;
      data_out <= '0;
      drop     <= 1'b0;
    end else begin
      drop <= load && !can_load;
      if (load && can_load) begin
        data_out <= data_in;
        valid    <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
// Collects an LSB-first serial bit stream into W-bit words and presents
// each completed word on a one-entry valid/ready output register.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : serial_word_deserializer_if.slave (serial input, word output,
//              out_parity_err, resync and drop pulses)
// Build option: SERIAL_WORD_DESERIALIZER_PARITY_EN adds a trailing even
// parity bit per word; without it out_parity_err is always 0.
module serial_word_deserializer
  import serial_word_deserializer_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input logic                        clk,
  input logic                        rst,
  serial_word_deserializer_if.slave  bus
);

  localparam int unsigned CW = count_width(W);

  state_t        state, state_d;
  logic [W-1:0]  sreg, sreg_d, base, load_word;
  logic [CW-1:0] cnt, cnt_d;
  logic          take, restart, load, perr_in;
  logic          resync_d, resync_q;
  logic [W:0]    held;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  logic          par, par_d;
`endif

  always_comb begin
    state_d   = state;
    sreg_d    = sreg;
    cnt_d     = cnt;
    base      = sreg;
    take      = 1'b0;
    restart   = 1'b0;
    load      = 1'b0;
    load_word = sreg;
    perr_in   = 1'b0;
    resync_d  = 1'b0;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
    par_d     = par;
`endif

    case (state)
      IDLE: begin
        if (bus.in_valid && bus.in_first) begin
          take    = 1'b1;
          restart = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.in_valid) begin
          take     = 1'b1;
          restart  = bus.in_first;
          resync_d = bus.in_first;
        end
      end
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
      PARITY: begin
        if (bus.in_valid) begin
          if (bus.in_first) begin
            take     = 1'b1;
            restart  = 1'b1;
            resync_d = 1'b1;
          end else begin
            load      = 1'b1;
            load_word = sreg;
            perr_in   = par ^ bus.in_bit;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A restart (first bit of a word, or resync) shifts into an empty
    // register, so IDLE capture and mid-word resync share one path.
    if (take) begin
      base   = restart ? '0 : sreg;
      sreg_d = (base >> 1) | (W'(bus.in_bit) << (W - 1));
      cnt_d  = restart ? CW'(1) : cnt + CW'(1);
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
      par_d  = restart ? bus.in_bit : par ^ bus.in_bit;
`endif
      if (cnt_d == CW'(W)) begin
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
        state_d = PARITY;
`else
        load      = 1'b1;
        load_word = sreg_d;
        cnt_d     = '0;
        state_d   = IDLE;
`endif
      end else begin
        state_d = SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      resync_q <= 1'b0;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      sreg     <= sreg_d;
      cnt      <= cnt_d;
      resync_q <= resync_d;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
      par      <= par_d;
`endif
    end
  end

  // Parity error travels with the word so both stay stable together.
  serial_out_reg #(
    .DW(W + 1)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data_in ({perr_in, load_word}),
    .valid   (bus.out_valid),
    .ready   (bus.out_ready),
    .data_out(held),
    .drop    (bus.drop)
  );

  assign bus.out_data       = held[W-1:0];
  assign bus.out_parity_err = held[W];
  assign bus.resync         = resync_q;

endmodule

// File: doc/serial_word_deserializer.md
Name: serial_word_deserializer

Overview:
- Receive end of the team's bit-serial datapath. Collects an LSB-first serial bit stream, such as the output of the serial adder, into a W-bit parallel word.
- Presents each completed word on a one-entry valid/ready output register.
- Flags resynchronisation and dropped words.
- Sits between a serial arithmetic stage and parallel consumers such as checkers and register files.

Parameters:
- W, 8, data word width in bits; legal range 1..64.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_bit is valid this cycle.
- in_first  input  1  qualifies in_bit as bit 0 (LSB) of a new word; ignored when in_valid=0.
- in_bit  input  1  serial data bit.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  W  assembled word; in_bit of the first accepted bit lands in out_data[0].
- out_parity_err  output  1  parity mismatch for the held word; constant 0 without the optional feature.
- resync  output  1  one-cycle pulse: in_first seen mid-word, partial word discarded.
- drop  output  1  one-cycle pulse: word completed while the output register was full and not draining; word lost.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, bit count=0, shift register=0, out_valid=0, out_data=0, out_parity_err=0, resync=0, drop=0.
- FSM states: IDLE, SHIFT, plus PARITY when the optional feature is on.
- IDLE:
  - in_valid && in_first: capture bit, count=1, go to SHIFT.
  - If W=1, the word completes this cycle and the FSM stays in IDLE.
  - in_valid without in_first: discarded silently.
- SHIFT:
  - Each in_valid cycle shifts right with in_bit entering the MSB, so after W bits the first bit sits at bit 0; count increments.
  - in_valid=0: hold state, no timeout.
  - in_valid && in_first: resync=1 next cycle; the partial word is discarded, the bit is taken as bit 0 of a new word, count=1.
  - When the W-th bit is accepted, the word is complete and the FSM returns to IDLE.
  - Back-to-back: in_first on the very next cycle is accepted.
- Word completion at posedge N:
  - If !out_valid, or out_valid && out_ready at N: out_data=word and out_valid=1 after N. Latency is one cycle from the last bit's edge.
  - Else out_data is unchanged and drop=1 for one cycle.
- Output handshake:
  - out_valid clears after an edge with out_valid && out_ready, unless a word loads on the same edge; then it stays 1 with the new data.
  - out_data and out_parity_err are stable while out_valid && !out_ready.
- Count width is $clog2(W+1); the counter never exceeds W.
- resync and drop are registered single-cycle pulses and mutually exclusive per cycle.
- Reset asserted mid-word: the partial word is lost, and out_valid/out_data are cleared immediately.

Optional Feature:
- Macro SERIAL_WORD_DESERIALIZER_PARITY_EN.
- Defined:
  - After the W-th data bit, the FSM enters PARITY and expects one more in_valid bit: even parity over the W data bits plus that bit.
  - in_first in PARITY acts as a resync.
  - The word completes on the parity bit; out_parity_err = XOR of all W+1 bits, loaded with out_data.
- Undefined: no PARITY state, words complete on the W-th bit, out_parity_err tied 0.

Decomposition:
- Package serial_word_deserializer_pkg:
  - state enum typedef (IDLE, SHIFT, PARITY);
  - function for count width given W.
- Sub-module serial_out_reg: one-entry valid/ready holding register with load, data_in and drop output. It is reusable by a future parallel-to-serial transmitter.

Test Plan (W=8):
- Reset, then feed 0xA5 as bits 1,0,1,0,0,1,0,1 with in_first on the first bit and out_ready=1 -> out_valid=1 with out_data=8'hA5 the cycle after the 8th bit, then out_valid=0 the following cycle.
- Words 0x3C then 0xFF back-to-back with no gap, out_ready=1 -> two consecutive words 8'h3C, 8'hFF; drop never asserts.
- out_ready=0; send 0x12 then 0x34 -> out_data holds 8'h12, drop pulses once on completion of 0x34; raise out_ready -> 0x12 accepted, out_valid=0.
- Send 3 bits of a word, then in_first with the full 0x81 -> resync pulses once, out_data=8'h81, no word from the partial bits.
- in_valid gaps of 0-3 cycles randomly inserted during 0x5A -> out_data=8'h5A; drive rst=0 mid-word 0x77 -> out_valid=0 immediately, no output for 0x77.
- PARITY_EN: 0xA5 with parity bit 0 -> out_parity_err=0; 0xA5 with parity bit 1 -> out_parity_err=1.
